// File: rtl/serv_mtimer.sv
// RISC-V machine timer: 64-bit mtime/mtimecmp on a 32-bit Wishbone slave, level interrupt out.
// Single-cycle ack after acceptance, never stalls; read data and o_mtip are registered.
module serv_mtimer #(
    parameter int PRESCALE = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [1:0]  i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_mtip
);

    localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    localparam logic [1:0] ADR_MTIME_LO = 2'd0;
    localparam logic [1:0] ADR_MTIME_HI = 2'd1;
    localparam logic [1:0] ADR_CMP_LO   = 2'd2;
    localparam logic [1:0] ADR_CMP_HI   = 2'd3;

    logic [PW-1:0] pre_q, pre_d;
    logic [63:0]   mtime_q, mtime_d;
    logic [63:0]   mtimecmp_q, mtimecmp_d;
    logic [31:0]   shadow_q, shadow_d;
    logic [31:0]   rdt_q, rdt_d;
    logic          ack_q, ack_d;
    logic          mtip_q, mtip_d;

    logic          tick;
    logic          acc;
    logic          wr;
    logic          rd;
    logic [31:0]   wr_mtime_lo;
    logic [31:0]   wr_mtime_hi;
    logic [31:0]   wr_cmp_lo;
    logic [31:0]   wr_cmp_hi;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  sel);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
                r[8*b +: 8] = new_w[8*b +: 8];
            end
        end
        return r;
    endfunction

    always_comb begin
        tick        = (pre_q == PRE_MAX);
        acc         = i_wb_cyc & i_wb_stb & ~ack_q;
        wr          = acc & i_wb_we;
        rd          = acc & ~i_wb_we;

        wr_mtime_lo = merge_bytes(mtime_q[31:0],     i_wb_dat, i_wb_sel);
        wr_mtime_hi = merge_bytes(mtime_q[63:32],    i_wb_dat, i_wb_sel);
        wr_cmp_lo   = merge_bytes(mtimecmp_q[31:0],  i_wb_dat, i_wb_sel);
        wr_cmp_hi   = merge_bytes(mtimecmp_q[63:32], i_wb_dat, i_wb_sel);

        pre_d       = tick ? '0 : pre_q + 1'b1;
        mtime_d     = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d  = mtimecmp_q;
        shadow_d    = shadow_q;
        rdt_d       = rdt_q;
        ack_d       = acc;
        mtip_d      = (mtime_q >= mtimecmp_q);

        // A write to either mtime word overrides the increment for the whole 64 bits.
        if (wr) begin
            case (i_wb_adr)
                ADR_MTIME_LO: mtime_d = {mtime_q[63:32], wr_mtime_lo};
                ADR_MTIME_HI: begin
                    mtime_d  = {wr_mtime_hi, mtime_q[31:0]};
                    shadow_d = wr_mtime_hi;
                end
                ADR_CMP_LO:   mtimecmp_d = {mtimecmp_q[63:32], wr_cmp_lo};
                ADR_CMP_HI:   mtimecmp_d = {wr_cmp_hi, mtimecmp_q[31:0]};
                default:      mtimecmp_d = mtimecmp_q;
            endcase
        end

        // Reading the low word freezes the high word so a lo-then-hi pair is coherent.
        if (rd) begin
            case (i_wb_adr)
                ADR_MTIME_LO: begin
                    rdt_d    = mtime_q[31:0];
                    shadow_d = mtime_q[63:32];
                end
                ADR_MTIME_HI: rdt_d = shadow_q;
                ADR_CMP_LO:   rdt_d = mtimecmp_q[31:0];
                ADR_CMP_HI:   rdt_d = mtimecmp_q[63:32];
                default:      rdt_d = rdt_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pre_q      <= '0;
            mtime_q    <= 64'd0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            shadow_q   <= 32'd0;
            rdt_q      <= 32'd0;
            ack_q      <= 1'b0;
            mtip_q     <= 1'b0;
        end else begin
            pre_q      <= pre_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            shadow_q   <= shadow_d;
            rdt_q      <= rdt_d;
            ack_q      <= ack_d;
            mtip_q     <= mtip_d;
        end
    end

    assign o_wb_rdt = rdt_q;
    assign o_wb_ack = ack_q;
    assign o_mtip   = mtip_q;

endmodule

// File: tb/tb_serv_mtimer.sv
// Bench for serv_mtimer: two instances (PRESCALE 1 and 4) on a shared bus, queue scoreboard on ack.
module tb_serv_mtimer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc1 = 1'b0;
    logic        cyc4 = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  adr = 2'd0;
    logic [31:0] dat = 32'd0;
    logic [3:0]  sel = 4'd0;
    logic [31:0] rdt1, rdt4;
    logic        ack1, ack4, mtip1, mtip4;
    logic [31:0] cnt = 32'd0;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic        rd;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];
    exp_t e1, e4;

    always #5 clk = ~clk;

    // cnt equals the cycle number since the last reset release.
    always @(posedge clk) cnt <= rst ? 32'd0 : cnt + 32'd1;

    serv_mtimer #(.PRESCALE(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc1), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
        .o_wb_rdt(rdt1), .o_wb_ack(ack1), .o_mtip(mtip1)
    );

    serv_mtimer #(.PRESCALE(4)) u_dut4 (
        .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc4), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
        .o_wb_rdt(rdt4), .o_wb_ack(ack4), .o_mtip(mtip4)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic push(input bit t4, input logic r, input logic [31:0] e, input string nm);
        exp_t x;
        x.rd   = r;
        x.exp  = e;
        x.name = nm;
        if (t4) q4.push_back(x);
        else    q1.push_back(x);
    endtask

    // Present a request for one cycle; returns #1 into the ack cycle.
    task automatic req(input bit t4, input logic w, input logic [1:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] e, input string nm);
        push(t4, ~w, e, nm);
        we  = w;
        adr = a;
        dat = d;
        sel = s;
        stb = 1'b1;
        if (t4) cyc4 = 1'b1;
        else    cyc1 = 1'b1;
        @(posedge clk); #1;
        stb  = 1'b0;
        cyc1 = 1'b0;
        cyc4 = 1'b0;
        we   = 1'b0;
    endtask

    task automatic acc(input bit t4, input logic w, input logic [1:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] e, input string nm);
        req(t4, w, a, d, s, e, nm);
        @(posedge clk); #1;
    endtask

    // Scoreboard monitor: every ack consumes one expectation; reads compare data.
    always @(negedge clk) begin
        if (ack1 === 1'b1) begin
            if (q1.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL dut1 unexpected ack: got ack with empty queue, required none");
            end else begin
                e1 = q1.pop_front();
                if (e1.rd) check(e1.name, rdt1, e1.exp);
            end
        end
        if (ack4 === 1'b1) begin
            if (q4.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL dut4 unexpected ack: got ack with empty queue, required none");
            end else begin
                e4 = q4.pop_front();
                if (e4.rd) check(e4.name, rdt4, e4.exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst ack1",  {31'd0, ack1},  32'd0);
        check("rst mtip1", {31'd0, mtip1}, 32'd0);
        check("rst rdt1",  rdt1,           32'd0);
        check("rst ack4",  {31'd0, ack4},  32'd0);
        check("rst mtip4", {31'd0, mtip4}, 32'd0);
        check("rst rdt4",  rdt4,           32'd0);

        // PRESCALE=1 free-run: request in cycle 10 sees mtime 10.
        repeat (10) begin @(posedge clk); #1; end
        acc(0, 0, 2'd0, 0, 4'h0, 32'd10,        "p1 mtime lo @10");
        acc(0, 0, 2'd1, 0, 4'h0, 32'd0,         "p1 shadow hi");
        acc(0, 0, 2'd2, 0, 4'h0, 32'hFFFF_FFFF, "p1 cmp lo reset");
        acc(0, 0, 2'd3, 0, 4'h0, 32'hFFFF_FFFF, "p1 cmp hi reset");

        acc(0, 1, 2'd2, 32'hAABB_CCDD, 4'b0101, 0, "wr");
        acc(0, 0, 2'd2, 0, 4'h0, 32'hFFBB_FFDD, "byte lanes cmp lo");

        // Carry: lo write collides with a tick, then 3 ticks wrap into hi.
        acc(0, 1, 2'd1, 32'd5,         4'hF, 0, "wr");
        acc(0, 1, 2'd0, 32'hFFFF_FFFE, 4'hF, 0, "wr");
        repeat (2) begin @(posedge clk); #1; end
        acc(0, 0, 2'd0, 0, 4'h0, 32'd1, "carry lo");
        acc(0, 0, 2'd1, 0, 4'h0, 32'd6, "carry hi");
        acc(0, 1, 2'd1, 32'd7, 4'hF, 0, "wr");
        acc(0, 0, 2'd1, 0, 4'h0, 32'd7, "hi write loads shadow");

        // Shadow must hold the pre-carry high half.
        acc(0, 1, 2'd0, 32'hFFFF_FFFD, 4'hF, 0, "wr");
        acc(0, 0, 2'd0, 0, 4'h0, 32'hFFFF_FFFE, "shadow lo");
        acc(0, 0, 2'd1, 0, 4'h0, 32'd7,         "shadow hi frozen");
        acc(0, 0, 2'd0, 0, 4'h0, 32'd2,         "post-carry lo");
        acc(0, 0, 2'd1, 0, 4'h0, 32'd8,         "post-carry hi");

        // Interrupt: mtime 90 at A+3, mtimecmp 100 from A+7, mtime==100 at A+13.
        acc(0, 1, 2'd1, 32'd0,   4'hF, 0, "wr");
        acc(0, 1, 2'd0, 32'd90,  4'hF, 0, "wr");
        acc(0, 1, 2'd2, 32'd100, 4'hF, 0, "wr");
        acc(0, 1, 2'd3, 32'd0,   4'hF, 0, "wr");
        for (int c = 8; c <= 14; c++) begin
            @(negedge clk);
            check($sformatf("mtip rise A+%0d", c), {31'd0, mtip1}, (c >= 14) ? 32'd1 : 32'd0);
        end
        @(posedge clk); #1;
        req(0, 1, 2'd2, 32'd500, 4'hF, 0, "wr");
        @(negedge clk);
        check("mtip in clear ack cycle", {31'd0, mtip1}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("mtip after clear", {31'd0, mtip1}, 32'd0);
        @(posedge clk); #1;
        acc(0, 0, 2'd2, 0, 4'h0, 32'd500, "cmp lo after clear");

        // Held request: ack 0,1,0,1,0,1 with three reads served.
        for (int i = 0; i < 3; i++) push(0, 1'b1, 32'd500, "held read");
        we = 1'b0; adr = 2'd2; stb = 1'b1; cyc1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("held ack %0d", i), {31'd0, ack1}, (i % 2 == 1) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
        end
        stb = 1'b0; cyc1 = 1'b0;
        @(posedge clk); #1;

        // PRESCALE=4: write lo=0 in a tick cycle T; mtime(T+k) = (k-1)/4.
        acc(1, 1, 2'd1, 32'd0, 4'hF, 0, "wr");
        for (int k = 0; k < 4 && cnt[1:0] != 2'd3; k++) begin @(posedge clk); #1; end
        acc(1, 1, 2'd0, 32'd0, 4'hF, 0, "wr");
        repeat (39) begin @(posedge clk); #1; end
        for (int i = 0; i < 5; i++)
            acc(1, 0, 2'd0, 0, 4'h0, 32'((40 + 2 * i) / 4), $sformatf("p4 lo T+%0d", 41 + 2 * i));

        // Collision with a non-zero value, then the next tick 4 cycles later.
        for (int k = 0; k < 4 && cnt[1:0] != 2'd3; k++) begin @(posedge clk); #1; end
        acc(1, 1, 2'd0, 32'hDEAD_BEEF, 4'hF, 0, "wr");
        acc(1, 0, 2'd0, 0, 4'h0, 32'hDEAD_BEEF, "p4 collision T2+2");
        acc(1, 0, 2'd0, 0, 4'h0, 32'hDEAD_BEEF, "p4 collision T2+4");
        acc(1, 0, 2'd0, 0, 4'h0, 32'hDEAD_BEF0, "p4 collision T2+6");

        // Reset during an access: no ack, no write.
        rst = 1'b1; we = 1'b1; adr = 2'd2; dat = 32'h55; sel = 4'hF; stb = 1'b1; cyc1 = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; stb = 1'b0; cyc1 = 1'b0; we = 1'b0;
        @(negedge clk);
        check("abort ack1",  {31'd0, ack1},  32'd0);
        check("abort rdt1",  rdt1,           32'd0);
        check("abort mtip1", {31'd0, mtip1}, 32'd0);
        @(posedge clk); #1;
        acc(0, 0, 2'd2, 0, 4'h0, 32'hFFFF_FFFF, "abort cmp lo kept");
        acc(0, 0, 2'd0, 0, 4'h0, 32'd3,         "mtime after reset");

        repeat (3) begin @(posedge clk); #1; end
        check("q1 drained", 32'(q1.size()), 32'd0);
        check("q4 drained", 32'(q4.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/serv_mtimer.md
# serv_mtimer

Memory-mapped RISC-V machine timer (mtime/mtimecmp) that generates the level-sensitive timer interrupt driving the core CSR unit's `i_mtip` input. It sits on the 32-bit Wishbone data bus next to RAM and GPIO, and counts prescaled clock ticks in a 64-bit counter. It asserts `o_mtip` while `mtime >= mtimecmp`, the condition the CSR unit gates with `mstatus.MIE` and `mie.MTIE`.

## Interface
- `PRESCALE`, default 1: clock cycles per mtime increment. Legal range 1..65536.
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset; synchronous, active-high.
- `i_wb_cyc`  in  1  Wishbone cycle.
- `i_wb_stb`  in  1  Wishbone strobe.
- `i_wb_we`  in  1  write enable.
- `i_wb_adr`  in  2  word address (byte address bits [3:2]).
- `i_wb_dat`  in  32  write data.
- `i_wb_sel`  in  4  byte lane enables.
- `o_wb_rdt`  out  32  read data.
- `o_wb_ack`  out  1  access acknowledge.
- `o_mtip`  out  1  timer interrupt pending, to the CSR unit's `i_mtip`.

## Operation
- Register map, by `i_wb_adr`:
  - 0: mtime[31:0]
  - 1: mtime[63:32]
  - 2: mtimecmp[31:0]
  - 3: mtimecmp[63:32]
- Prescaler: counter `pre` counts 0..PRESCALE-1.
  - `tick` is high in the cycle where `pre == PRESCALE-1`; `pre` wraps to 0 in that cycle.
  - With PRESCALE=1, `tick` is high every cycle.
- mtime: 64-bit counter, incremented by 1 on `tick`. Carry propagates from the low half into the high half; 2^64-1 wraps to 0.
- Access acceptance: an access is accepted when `i_wb_cyc & i_wb_stb & !o_wb_ack`.
- Writes: merge byte-wise per `i_wb_sel` into the addressed word; unselected bytes are unchanged.
- Write vs tick collision: a write to either mtime word in the same cycle as `tick` takes priority for the whole 64-bit counter. mtime becomes the old value with the written bytes replaced; that tick is lost. No increment and no carry occur that cycle.
- mtimecmp writes never affect mtime or `pre`.
- Atomic 64-bit read of mtime:
  - Reading word 0 returns mtime[31:0] and captures mtime[63:32] into a shadow register, from the same cycle's value.
  - Reading word 1 returns the shadow, not the live high half.
  - Any write to word 1 also loads the shadow with the new high half.
- mtimecmp reads return the live value.
- Interrupt:
  - `o_mtip` is registered: `o_mtip <= (mtime >= mtimecmp)`, an unsigned 64-bit compare of the current-cycle register values.
  - It is a level, not a pulse. It stays high until mtimecmp is raised above mtime or mtime wraps.
  - Software clears it by writing mtimecmp. The recommended order is write word 3 = 0xFFFFFFFF, then word 2, then word 3, which avoids spurious matches.

## Timing
- Reset values:
  - mtime = 0
  - mtimecmp = 0xFFFF_FFFF_FFFF_FFFF
  - `pre` = 0
  - shadow = 0
  - `o_mtip` = 0
  - `o_wb_ack` = 0
  - `o_wb_rdt` = 0
- Reset applied mid-access aborts the access: no ack is issued and no register is written in the reset cycle.
- Ack timing:
  - `o_wb_ack` is high exactly one cycle, in the cycle after acceptance.
  - It is deasserted the following cycle even if `cyc`/`stb` are still high.
  - A held request is therefore re-accepted every second cycle. The master must drop `stb` on ack.
- Reads: `o_wb_rdt` is registered, sampled in the accepting cycle, and valid while `o_wb_ack` is high. It holds its value otherwise.
- Writes: the register update is visible in the cycle of `o_wb_ack`, i.e. one cycle after acceptance.
- Interrupt latency:
  - `o_mtip` rises one cycle after mtime reaches mtimecmp.
  - It falls one cycle after a write makes `mtime < mtimecmp`, i.e. the cycle after the write's ack cycle.
- Tick timing: first tick after reset is at cycle PRESCALE-1 (counting the first cycle after reset release as cycle 0). mtime = 1 from cycle PRESCALE.

## Test plan
- Reset, PRESCALE=1, idle 10 cycles → mtime reads 10 or 11 (per exact read cycle), `o_mtip`=0, read word 2/3 → 0xFFFFFFFF.
- PRESCALE=4: write mtime lo=0, hi=0, then idle 40 cycles → read lo returns 10±1. Confirm the increment occurs exactly every 4th cycle.
- Carry and shadow: write lo=0xFFFFFFFE, hi=0x00000005, run 3 ticks, read lo → 0x00000001, read hi → 0x00000006. Then set hi to 7 via a write and read hi immediately → 7.
- Interrupt:
  - Set mtimecmp=100 with mtime=90 → `o_mtip` rises one cycle after mtime==100.
  - Write mtimecmp lo=500 → `o_mtip` falls the cycle after the ack.
- Byte lanes: write word 2 = 0xAABBCCDD with sel=4'b0101 over the reset value → word 2 reads 0xFFBBFFDD.
- Collision and handshake: write mtime lo in a tick cycle → the written value is read back exactly (no +1). Hold `cyc`/`stb` high for 6 cycles → ack pattern 0,1,0,1,0,1.
